// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, FSM state type and sizing helpers for the pooling stage
package conv_pkg;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  localparam int DEF_IN_W = 4;
  localparam int DEF_IN_H = 4;
  localparam int DEF_POOL = 2;
  localparam int DEF_WL   = 32;
  localparam int OUT_W    = DEF_IN_W / DEF_POOL;
  localparam int OUT_H    = DEF_IN_H / DEF_POOL;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} pool_state_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp32_gt_cmp.sv
// rtl/fp32_gt_cmp.sv - combinational float32 strict greater-than with NaN detect on operand a
module fp32_gt_cmp
  import conv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b,
  output logic        a_is_nan
);

  logic both_zero;

  always_comb begin
    a_is_nan  = (a[30:23] == FP32_EXP_MAX) && (a[22:0] != 23'd0);
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    // Sign-magnitude order; +0 and -0 are equal so neither wins
    if (both_zero)
      a_gt_b = 1'b0;
    else if (a[31] != b[31])
      a_gt_b = b[31];
    else if (a[31])
      a_gt_b = a[30:0] < b[30:0];
    else
      a_gt_b = a[30:0] > b[30:0];
  end

endmodule

// File: rtl/conv_maxpool_stream.sv
// rtl/conv_maxpool_stream.sv - sequential 2x2 float32 max pooling over a captured map, streamed out
// Optional ReLU on emitted words when CONV_POOL_RELU_EN is defined.
module conv_maxpool_stream
  import conv_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int IN_H = DEF_IN_H,
  parameter int WL   = DEF_WL,
  parameter int POOL = DEF_POOL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W*IN_H*WL-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WL-1:0]          out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int NW = IN_W * IN_H;
  localparam int OW = IN_W / POOL;
  localparam int OH = IN_H / POOL;
  localparam int NK = POOL * POOL;
  localparam int AW = cnt_w(NW);
  localparam int CW = cnt_w(OW);
  localparam int RW = cnt_w(OH);
  localparam int KW = cnt_w(NK);

  pool_state_e       state_q;
  logic [NW*WL-1:0]  map_q;
  logic [RW-1:0]     orow_q;
  logic [CW-1:0]     ocol_q;
  logic [KW-1:0]     k_q;
  logic              prime_q;
  logic [WL-1:0]     acc_q;
  logic              nan_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WL-1:0]     out_data_q;
  logic              out_last_q;

  logic [WL-1:0]     word_w [NW];
  logic [31:0]       row, col;
  logic [AW-1:0]     idx;
  logic [WL-1:0]     elem, acc_d, emit_word;
  logic              nan_d, elem_gt, elem_nan, last_win;

  for (genvar g = 0; g < NW; g++) begin : g_words
    assign word_w[g] = map_q[g*WL +: WL];
  end

  fp32_gt_cmp u_cmp (
    .a        (elem),
    .b        (acc_q),
    .a_gt_b   (elem_gt),
    .a_is_nan (elem_nan)
  );

  always_comb begin
    row       = 32'(orow_q) * POOL + 32'(k_q) / POOL;
    col       = 32'(ocol_q) * POOL + 32'(k_q) % POOL;
    idx       = AW'(row * IN_W + col);
    elem      = word_w[idx];
    acc_d     = ((k_q == '0) || elem_gt) ? elem : acc_q;
    nan_d     = (k_q == '0) ? elem_nan : (nan_q | elem_nan);
    last_win  = (orow_q == RW'(OH - 1)) && (ocol_q == CW'(OW - 1));
`ifdef CONV_POOL_RELU_EN
    emit_word = nan_d ? FP32_QNAN : (acc_d[WL-1] ? FP32_ZERO : acc_d);
`else
    emit_word = nan_d ? FP32_QNAN : acc_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      map_q       <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      k_q         <= '0;
      prime_q     <= 1'b0;
      acc_q       <= '0;
      nan_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= FP32_ZERO;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            map_q      <= in_data;
            orow_q     <= '0;
            ocol_q     <= '0;
            k_q        <= '0;
            prime_q    <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          // One settle cycle after capture keeps first-word latency at 1+POOL*POOL
          if (prime_q) begin
            prime_q <= 1'b0;
          end else begin
            acc_q <= acc_d;
            nan_q <= nan_d;
            if (k_q == KW'(NK - 1)) begin
              k_q         <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= emit_word;
              out_last_q  <= last_win;
              state_q     <= EMIT;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (last_win) begin
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              if (ocol_q == CW'(OW - 1)) begin
                ocol_q <= '0;
                orow_q <= orow_q + 1'b1;
              end else begin
                ocol_q <= ocol_q + 1'b1;
              end
              state_q <= SCAN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_maxpool_stream.sv
// tb/tb_conv_maxpool_stream.sv - scoreboard bench for conv_maxpool_stream with a float32 reference model
module tb_conv_maxpool_stream;

  localparam int IN_W = 4;
  localparam int IN_H = 4;
  localparam int WL   = 32;
  localparam int NW   = IN_W * IN_H;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NW*WL-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WL-1:0]     out_data;
  logic              out_last;
  logic              busy;

  conv_maxpool_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int nwords = 0, nlast = 0, accept_cyc = 0, hs_cyc = 0;
  bit first_pending = 0, prev_valid = 0;
  logic [32:0] exp_q [$];
  logic [31:0] mapv [NW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: order non-NaN floats by a signed integer key (+0 == -0)
  function automatic longint fkey(input logic [31:0] w);
    longint m;
    m = longint'(w[30:0]);
    return w[31] ? -m : m;
  endfunction

  function automatic bit is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 0);
  endfunction

  function automatic logic [31:0] pool_ref(input logic [31:0] e0, e1, e2, e3);
    logic [31:0] e [4];
    logic [31:0] best;
    bit nan;
    e = '{e0, e1, e2, e3};
    best = e[0];
    nan = 0;
    for (int i = 0; i < 4; i++) begin
      if (is_nan(e[i])) nan = 1;
      if (i > 0 && fkey(e[i]) > fkey(best)) best = e[i];
    end
    if (nan) return 32'h7FC0_0000;
`ifdef CONV_POOL_RELU_EN
    if (best[31]) return 32'h0;
`endif
    return best;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int unsigned s, m;
    s = $urandom_range(0, 1);
    m = $urandom_range(1, 8388607);
    case ($urandom_range(0, 15))
      0: w = 32'h0000_0000;
      1: w = 32'h8000_0000;
      2: w = 32'h7F80_0000;
      3: w = 32'hFF80_0000;
      4: w = {s[0], 8'hFF, m[22:0]};
      5, 6: w = {s[0], 8'h80, 23'h0};
      default: begin
        w = $urandom;
        if (w[30:23] == 8'hFF) w[30] = 1'b0;
      end
    endcase
    return w;
  endfunction

  task automatic set_win(input int w, input logic [31:0] a, b, c, d);
    int base;
    base = (w / 2) * 2 * IN_W + (w % 2) * 2;
    mapv[base] = a; mapv[base+1] = b; mapv[base+IN_W] = c; mapv[base+IN_W+1] = d;
  endtask

  task automatic push_model();
    int b;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        b = r * 2 * IN_W + c * 2;
        exp_q.push_back({1'(r == 1 && c == 1),
                         pool_ref(mapv[b], mapv[b+1], mapv[b+IN_W], mapv[b+IN_W+1])});
      end
  endtask

  task automatic send_map();
    bit ok;
    ok = 0;
    for (int i = 0; i < NW; i++) in_data[i*WL +: WL] = mapv[i];
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL accept_timeout actual=0 required=1"); end
  endtask

  task automatic drain(input bit rnd);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exp_q.size() == 0 && in_ready) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL drain_timeout actual=%0d required=0", exp_q.size()); end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      prev_valid = 0;
      first_pending = 0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (first_pending) begin
          check("first_latency", 32'(cyc - accept_cyc), 32'd5);
          first_pending = 0;
        end else begin
          check("word_latency", 32'(cyc - hs_cyc), 32'd4);
        end
      end
      prev_valid = out_valid;
      if (in_valid && in_ready) begin accept_cyc = cyc + 1; first_pending = 1; end
      if (out_valid && out_ready) begin
        hs_cyc = cyc + 1;
        nwords++;
        if (out_last) nlast++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_last", 32'(out_last), 32'(e[32]));
        end
      end
    end
  end

  task automatic load_basic();
    for (int i = 0; i < NW; i++) mapv[i] = 32'h3F80_0000;
    mapv[0] = 32'h3F80_0000; mapv[1] = 32'h4000_0000; mapv[2] = 32'hBF80_0000; mapv[3] = 32'h3F00_0000;
    mapv[4] = 32'h3F00_0000; mapv[5] = 32'hC040_0000; mapv[6] = 32'hC040_0000; mapv[7] = 32'hBF80_0000;
    exp_q.push_back({1'b0, 32'h4000_0000});
    exp_q.push_back({1'b0, 32'h3F00_0000});
    exp_q.push_back({1'b0, 32'h3F80_0000});
    exp_q.push_back({1'b1, 32'h3F80_0000});
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 1);

    out_ready = 1'b1;
    load_basic();
    send_map();
    drain(0);

    out_ready = 1'b0;
    load_basic();
    send_map();
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL bp_wait_valid actual=0 required=1"); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in_data = {NW{32'hDEAD_BEEF}};
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_data", out_data, 32'h4000_0000);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(0);

    set_win(0, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    set_win(1, 32'h3F80_0000, 32'h7FC0_0001, 32'h4000_0000, 32'hFF80_0000);
    set_win(2, 32'h7F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    set_win(3, 32'hC040_0000, 32'hC040_0000, 32'hC040_0000, 32'hC040_0000);
    push_model();
    send_map();
    drain(1);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NW; i++) mapv[i] = rand_word();
      push_model();
      send_map();
      drain(1);
    end

    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) mapv[i] = rand_word();
    push_model();
    send_map();
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 3) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL mid_wait actual=%0d required=3", exp_q.size()); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_last", 32'(out_last), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nwords = 0;
    nlast = 0;
    for (int i = 0; i < NW; i++) mapv[i] = rand_word();
    push_model();
    send_map();
    drain(0);
    repeat (10) @(posedge clk);
    check("post_rst_words", 32'(nwords), 4);
    check("post_rst_lasts", 32'(nlast), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
